apb_master_mc: RTL and testbench
================================

// Module: apb_master_mc
// PURPOSE
//  Parametrised APB4 master bridging a simple command/response port onto an APB bus with NUM_SLAVES selects.
//  Successor to the single-width two-select master: generic widths, address-decoded PSEL, PSTRB, wait-state timeout.
//  Sits between the system-side request engine and the APB slave fabric; one transfer in flight at a time.
// PARAMETERS
//  ADDR_WIDTH      8   PADDR / cmd_addr width
//  DATA_WIDTH      8   PWDATA/PRDATA width; multiple of 8
//  NUM_SLAVES      2   number of PSEL lines; SLV_BITS = max(1,$clog2(NUM_SLAVES))
//  TIMEOUT_CYCLES  16  max wait-state cycles in ACCESS before abort; 0 disables timeout
// PORTS
//  PCLK          in   1                       APB clock
//  PRESETn       in   1                       async active-low reset
//  cmd_valid     in   1                       command request
//  cmd_ready     out  1                       master can accept command
//  cmd_write     in   1                       1=write, 0=read
//  cmd_addr      in   ADDR_WIDTH              byte address; top SLV_BITS select slave
//  cmd_wdata     in   DATA_WIDTH              write data
//  cmd_strb      in   DATA_WIDTH/8            write byte strobes
//  rsp_valid     out  1                       one-cycle completion pulse, no backpressure
//  rsp_rdata     out  DATA_WIDTH              read data (0 for writes/errors)
//  rsp_err       out  1                       PSLVERR, decode error, or timeout
//  rsp_timeout   out  1                       error was a timeout
//  PSEL          out  NUM_SLAVES              one-hot slave select
//  PENABLE       out  1                       APB access phase
//  PADDR         out  ADDR_WIDTH              APB address
//  PWRITE        out  1                       APB direction
//  PWDATA        out  DATA_WIDTH              APB write data
//  PSTRB         out  DATA_WIDTH/8            APB write strobes
//  PREADY        in   NUM_SLAVES              per-slave ready
//  PRDATA        in   NUM_SLAVES*DATA_WIDTH   per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//  PSLVERR       in   NUM_SLAVES              per-slave error
// BEHAVIOUR
//  Reset (async, PRESETn=0): state=IDLE; PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0,
//   rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, wait counter=0. cmd_ready=1 once reset released.
//  All outputs registered except cmd_ready (=1 iff state==IDLE).
//  FSM IDLE/SETUP/ACCESS:
//   IDLE: cmd_valid&cmd_ready accepts; idx=cmd_addr[ADDR_WIDTH-1 -: SLV_BITS].
//    idx<NUM_SLAVES -> SETUP; latch PADDR, PWRITE, PWDATA=cmd_wdata (0 on read), PSTRB=cmd_strb (0 on read).
//    idx>=NUM_SLAVES -> stay IDLE, no PSEL; next cycle rsp_valid=1, rsp_err=1, rsp_timeout=0.
//   SETUP (1 cycle): PSEL[idx]=1, PENABLE=0 -> ACCESS.
//   ACCESS: PSEL[idx]=1, PENABLE=1; sample only PREADY[idx]/PSLVERR[idx]/PRDATA slice idx.
//    PREADY[idx]=1 -> IDLE; next cycle rsp_valid=1, rsp_err=PSLVERR[idx], rsp_rdata=read&&!err ? PRDATA[idx] : 0.
//    PREADY[idx]=0 -> wait counter++; counter==TIMEOUT_CYCLES (nonzero) -> abort to IDLE,
//     rsp_valid=1, rsp_err=1, rsp_timeout=1 next cycle.
//  Entering IDLE clears PSEL and PENABLE; PADDR/PWRITE/PWDATA/PSTRB hold until next accept.
//  PADDR/PWRITE/PWDATA/PSTRB stable from SETUP through last ACCESS cycle.
//  Latency: accept (cyc 0) -> SETUP cyc 1 -> ACCESS cyc 2; zero-wait rsp_valid cyc 3; +1 per wait state.
//  Back-to-back: cmd_ready is high in the rsp_valid cycle; next SETUP at earliest 1 cycle after that.
//  Wait counter: clears on SETUP entry; width $clog2(TIMEOUT_CYCLES+1); never wraps.
//   PREADY on the same cycle the counter hits the limit wins (normal completion).
//  PSLVERR ignored unless PREADY[idx]=1 (APB4). Non-selected slaves' inputs ignored.
//  Reset mid-transfer: PSEL/PENABLE drop immediately (async); no rsp_valid generated for lost command.
//  cmd_* ignored whenever cmd_ready=0.
// TESTING
//  1 Write 0x5A to addr 0x12 (slave 0), PREADY=1 at once -> SETUP cyc1, ACCESS cyc2, PSTRB=1, rsp_valid cyc3, err=0.
//  2 Read addr 0x83 (slave 1), PREADY[1] low 3 cycles, PRDATA=0xC3 -> PENABLE 4 cycles, rsp_rdata=0xC3 cyc6.
//  3 TIMEOUT_CYCLES=4, PREADY never -> abort after 4 wait cycles, rsp_err=1, rsp_timeout=1, PSEL back to 0.
//  4 NUM_SLAVES=3, addr idx 3 -> PSEL never asserts, rsp_valid+rsp_err next cycle, rsp_timeout=0.
//  5 Read with PREADY=1, PSLVERR=1 -> rsp_err=1, rsp_rdata=0; PSLVERR=1 with PREADY=0 -> ignored.
//  6 PRESETn low during ACCESS -> PSEL/PENABLE 0 same cycle, no rsp_valid, new command accepted after release.

Source files
------------

// File: rtl/apb_master_mc.sv
// APB4 master: one command/response transfer at a time onto NUM_SLAVES address-decoded selects,
// with byte strobes and an optional wait-state timeout.
module apb_master_mc #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_SLAVES     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_write,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr,
    input  logic [DATA_WIDTH-1:0]            cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             rsp_timeout,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);
    localparam int SLV_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [SLV_BITS:0]  NSLV = NUM_SLAVES[SLV_BITS:0];
    localparam logic [CNT_W-1:0]   TMO  = TIMEOUT_CYCLES[CNT_W-1:0];

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t                  state_q;
    logic [SLV_BITS-1:0]     idx_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_SLAVES-1:0]   psel_q;
    logic                    penable_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic                    pwrite_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [STRB_W-1:0]       pstrb_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    rsp_timeout_q;

    logic [SLV_BITS-1:0]     cmd_idx;
    logic                    cmd_in_range;
    logic [NUM_SLAVES-1:0]   cmd_onehot;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    tmo_hit;

    assign cmd_idx      = cmd_addr[ADDR_WIDTH-1 -: SLV_BITS];
    assign cmd_in_range = ({1'b0, cmd_idx} < NSLV);
    assign cmd_onehot   = {{(NUM_SLAVES-1){1'b0}}, 1'b1} << cmd_idx;
    assign sel_ready    = PREADY[idx_q];
    assign sel_err      = PSLVERR[idx_q];
    assign sel_rdata    = PRDATA[idx_q*DATA_WIDTH +: DATA_WIDTH];
    assign cnt_nxt      = cnt_q + 1'b1;
    // The cycle whose missing PREADY would be the TIMEOUT_CYCLES-th wait aborts.
    assign tmo_hit      = (TIMEOUT_CYCLES != 0) && (cnt_nxt == TMO);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_in_range) begin
                            state_q  <= S_SETUP;
                            idx_q    <= cmd_idx;
                            cnt_q    <= '0;
                            psel_q   <= cmd_onehot;
                            paddr_q  <= cmd_addr;
                            pwrite_q <= cmd_write;
                            pwdata_q <= cmd_write ? cmd_wdata : '0;
                            pstrb_q  <= cmd_write ? cmd_strb  : '0;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (sel_ready) begin
                        state_q     <= S_IDLE;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= sel_err;
                        rsp_rdata_q <= (!pwrite_q && !sel_err) ? sel_rdata : '0;
                    end else if (tmo_hit) begin
                        state_q       <= S_IDLE;
                        psel_q        <= '0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                    end else if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_nxt;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_mc.sv
// Directed bench for apb_master_mc: 3 slaves (idx = addr[7:6], idx 3 undecoded), timeout of 4 wait cycles.
module tb_apb_master_mc;
    localparam int NS = 3;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr, cmd_wdata;
    logic [0:0]  cmd_strb;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [7:0]  rsp_rdata;
    logic [NS-1:0] PSEL;
    logic        PENABLE, PWRITE;
    logic [7:0]  PADDR, PWDATA;
    logic [0:0]  PSTRB;
    logic [NS-1:0] PREADY, PSLVERR;
    logic [NS*8-1:0] PRDATA;

    int n_pass = 0;
    int n_total = 0;

    apb_master_mc #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       strb;
        bit         dec;       // undecoded address
        int         waits;     // wait cycles before PREADY, -1 = never
        bit         slverr;    // PSLVERR with PREADY
        bit         err_wait;  // PSLVERR also during wait cycles
        logic [7:0] prdata;
        bit         exp_err;
        bit         exp_to;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic run_vec(input vec_t v);
        int idx;
        int k;
        bit last;
        logic [NS-1:0] oh;
        idx = int'(v.addr[7:6]);
        oh  = 3'(1) << idx;
        @(negedge PCLK);
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_strb = v.strb;
        @(negedge PCLK);
        if (v.dec) begin
            cmd_valid = 1'b0;
            chk("dec_rsp_valid", rsp_valid, 1);
            chk("dec_rsp_err", rsp_err, 1);
            chk("dec_rsp_timeout", rsp_timeout, 0);
            chk("dec_psel", PSEL, 0);
            @(negedge PCLK);
            chk("dec_rsp_drop", rsp_valid, 0);
            chk("dec_psel_after", PSEL, 0);
            return;
        end
        // Keep a conflicting command pending while busy; it must be ignored.
        cmd_addr = ~v.addr; cmd_write = ~v.wr; cmd_wdata = ~v.wdata;
        chk("setup_psel", PSEL, oh);
        chk("setup_penable", PENABLE, 0);
        chk("setup_paddr", PADDR, v.addr);
        chk("setup_pwrite", PWRITE, v.wr);
        chk("setup_pwdata", PWDATA, v.wr ? v.wdata : 8'h00);
        chk("setup_pstrb", PSTRB, v.wr ? v.strb : 1'b0);
        chk("setup_ready", cmd_ready, 0);
        @(negedge PCLK);
        last = 1'b0;
        for (k = 0; k < 20 && !last; k++) begin
            chk("acc_penable", PENABLE, 1);
            chk("acc_psel", PSEL, oh);
            chk("acc_paddr", PADDR, v.addr);
            chk("acc_rsp_valid", rsp_valid, 0);
            PREADY  = ~oh;
            PSLVERR = ~oh;
            PRDATA  = 24'hEEEEEE;
            if (k == v.waits) begin
                PREADY[idx]  = 1'b1;
                PSLVERR[idx] = v.slverr;
                PRDATA[idx*8 +: 8] = v.prdata;
                last = 1'b1;
            end else begin
                PSLVERR[idx] = v.err_wait;
                if (v.waits < 0 && k == 3) last = 1'b1;
            end
            if (last) cmd_valid = 1'b0;
            @(negedge PCLK);
            PREADY = '0; PSLVERR = '0; PRDATA = '0;
        end
        chk("access_cycles", k, (v.waits < 0) ? 4 : v.waits + 1);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_err", rsp_err, v.exp_err);
        chk("rsp_timeout", rsp_timeout, v.exp_to);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_psel", PSEL, 0);
        chk("rsp_penable", PENABLE, 0);
        chk("rsp_cmd_ready", cmd_ready, 1);
        chk("hold_paddr", PADDR, v.addr);
        @(negedge PCLK);
        chk("rsp_pulse_end", rsp_valid, 0);
    endtask

    initial begin
        //            wr  addr   wdata  strb dec waits sle ew  prdata err to rdata
        tbl[0] = '{1, 8'h12, 8'h5A, 1'b1, 0,  0, 0, 0, 8'h00, 0, 0, 8'h00};
        tbl[1] = '{0, 8'h43, 8'h99, 1'b1, 0,  3, 0, 0, 8'hC3, 0, 0, 8'hC3};
        tbl[2] = '{1, 8'h80, 8'h11, 1'b1, 0, -1, 0, 0, 8'h00, 1, 1, 8'h00};
        tbl[3] = '{0, 8'hC5, 8'h00, 1'b0, 1,  0, 0, 0, 8'h00, 1, 0, 8'h00};
        tbl[4] = '{0, 8'h05, 8'h00, 1'b0, 0,  0, 1, 0, 8'h77, 1, 0, 8'h00};
        tbl[5] = '{0, 8'h07, 8'h00, 1'b0, 0,  2, 0, 1, 8'h3C, 0, 0, 8'h3C};
        tbl[6] = '{0, 8'h9F, 8'h00, 1'b0, 0,  3, 0, 0, 8'hA5, 0, 0, 8'hA5};
        tbl[7] = '{1, 8'h44, 8'hFF, 1'b0, 0,  1, 1, 0, 8'h00, 1, 0, 8'h00};

        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; PREADY = '0; PSLVERR = '0; PRDATA = '0;
        #12;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("post_rst_ready", cmd_ready, 1);

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Reset while in ACCESS: selects drop asynchronously, no response for the lost command.
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h41;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("pre_rst_penable", PENABLE, 1);
        #2 PRESETn = 1'b0;
        #1;
        chk("async_psel", PSEL, 0);
        chk("async_penable", PENABLE, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("no_rsp_after_rst", rsp_valid, 0);
            chk("idle_after_rst", cmd_ready, 1);
        end
        run_vec(tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
